// File: rtl/cu_pkg.sv
// Shared constants for the sequencing control unit: opcodes, register-reference
// bit positions and the final execute step of each instruction class.
package cu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_IO  = 3'd7
  } opcode_t;

  // Register-reference instruction bits the control unit reacts to.
  localparam int CLA_BIT = 11;
  localparam int CMA_BIT = 9;
  localparam int CIR_BIT = 7;
  localparam int CIL_BIT = 6;
  localparam int INC_BIT = 5;
  localparam int HLT_BIT = 0;

  // Step on which SC clears for each instruction class.
  localparam logic [2:0] LAST_REG_IO = 3'd3;
  localparam logic [2:0] LAST_STA    = 3'd4;
  localparam logic [2:0] LAST_BUN    = 3'd4;
  localparam logic [2:0] LAST_ALU    = 3'd5;
  localparam logic [2:0] LAST_BSA    = 3'd5;
  localparam logic [2:0] LAST_ISZ    = 3'd6;

  function automatic logic [2:0] last_step(input logic [2:0] op);
    case (op)
      OP_AND, OP_ADD, OP_LDA: last_step = LAST_ALU;
      OP_STA:                 last_step = LAST_STA;
      OP_BUN:                 last_step = LAST_BUN;
      OP_BSA:                 last_step = LAST_BSA;
      OP_ISZ:                 last_step = LAST_ISZ;
      default:                last_step = LAST_REG_IO;
    endcase
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Sequence counter: synchronous clear beats increment; one-hot decode of the
// count and a wrap flag for the overflow case.
module seq_counter #(
  parameter int SC_W = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [SC_W-1:0]        count,
  output logic [(2**SC_W)-1:0]   onehot,
  output logic                   wrap
);

  logic [SC_W-1:0] count_reg;

  // Count register: reset, then clear, then increment.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + SC_W'(1);
    end
  end

  assign count = count_reg;
  assign wrap  = inc & ~clr & (&count_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2**SC_W; gi++) begin : g_decode
      assign onehot[gi] = (count_reg == SC_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/seq_control_unit.sv
// Basic-computer control unit with internal timing: sequence counter, latched
// opcode/indirect bit, interrupt flip-flop R and halt flag. Strobes are
// combinational from state so each one acts on the closing edge of its Tn.
module seq_control_unit
  import cu_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int SC_W   = 4      // must be at least 3 so T0..T6 exist
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [WORD_W-1:0]    IR,
  input  logic                 INTERRUPT_REQ,
  output logic [(2**SC_W)-1:0] TIME_SIGNAL,
  output logic [7:0]           DEC_SIGNAL,
  output logic                 INDIRECT_BIT,
  output logic                 INTERRUPT_R,
  output logic                 HALTED,
  output logic                 SEQ_ERR,
  output logic                 MEMORY_READ,
  output logic                 MEMORY_WRITE,
  output logic                 IR_LOAD,
  output logic                 TR_LOAD,
  output logic                 ALU_LOAD,
  output logic                 ALU_CLEAR,
  output logic                 ALU_INC,
  output logic                 AR_LOAD,
  output logic                 AR_INC,
  output logic                 AR_CLEAR,
  output logic                 DR_LOAD,
  output logic                 DR_INC,
  output logic                 PC_LOAD,
  output logic                 PC_CLEAR,
  output logic                 PC_INC,
  output logic                 IEN_CLEAR
);

  logic [2:0]      d_reg;
  logic            i_reg;
  logic            r_reg;
  logic            halt_reg;
  logic            seq_err_reg;
  logic [SC_W-1:0] sc_count;
  logic            sc_wrap;
  logic            run;
  logic            strobe_en;
  logic            sc_clr;
  logic            halt_set;
  logic            r_set;
  logic            r_clr;
  logic            unused_ir;

  // Spare IR bits (CLE, CME, skips, ...) are acted on by the datapath only.
  assign unused_ir = ^IR;

  assign run       = ENABLE & ~halt_reg;
  // Strobes are also held off while RESET is high so an aborted step never fires.
  assign strobe_en = run & ~RESET;

  assign halt_set = run & TIME_SIGNAL[3] & (d_reg == OP_IO) & ~i_reg & IR[HLT_BIT];
  assign sc_clr   = run & ((r_reg & TIME_SIGNAL[2]) |
                           (sc_count == SC_W'(last_step(d_reg))));
  assign r_clr    = run & r_reg & TIME_SIGNAL[2];
  assign r_set    = run & INTERRUPT_REQ & ~r_reg & ~halt_set &
                    ~(TIME_SIGNAL[0] | TIME_SIGNAL[1] | TIME_SIGNAL[2]);

  seq_counter #(.SC_W(SC_W)) u_sc (
    .clk    (CLK),
    .srst   (RESET),
    .clr    (sc_clr),
    .inc    (run),
    .count  (sc_count),
    .onehot (TIME_SIGNAL),
    .wrap   (sc_wrap)
  );

  // Opcode and indirect latches load at the end of fetch T2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      d_reg <= OP_AND;
      i_reg <= 1'b0;
    end else if (run & ~r_reg & TIME_SIGNAL[2]) begin
      d_reg <= IR[WORD_W-2 -: 3];
      i_reg <= IR[WORD_W-1];
    end
  end

  // R, HALT and the SC-wrap pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_reg       <= 1'b0;
      halt_reg    <= 1'b0;
      seq_err_reg <= 1'b0;
    end else begin
      if (r_clr) begin
        r_reg <= 1'b0;
      end else if (r_set) begin
        r_reg <= 1'b1;
      end
      if (halt_set) begin
        halt_reg <= 1'b1;
      end
      seq_err_reg <= sc_wrap;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign DEC_SIGNAL[gi] = (d_reg == 3'(gi));
    end
  endgenerate

  assign INDIRECT_BIT = i_reg;
  assign INTERRUPT_R  = r_reg;
  assign HALTED       = halt_reg;
  assign SEQ_ERR      = seq_err_reg;

  // Strobe decode from (R, SC, D, I) and, for register reference, IR bits.
  always_comb begin
    MEMORY_READ  = 1'b0;
    MEMORY_WRITE = 1'b0;
    IR_LOAD      = 1'b0;
    TR_LOAD      = 1'b0;
    ALU_LOAD     = 1'b0;
    ALU_CLEAR    = 1'b0;
    ALU_INC      = 1'b0;
    AR_LOAD      = 1'b0;
    AR_INC       = 1'b0;
    AR_CLEAR     = 1'b0;
    DR_LOAD      = 1'b0;
    DR_INC       = 1'b0;
    PC_LOAD      = 1'b0;
    PC_CLEAR     = 1'b0;
    PC_INC       = 1'b0;
    IEN_CLEAR    = 1'b0;
    if (strobe_en) begin
      if (!r_reg) begin
        if (TIME_SIGNAL[0]) AR_LOAD = 1'b1;
        if (TIME_SIGNAL[1]) begin
          MEMORY_READ = 1'b1;
          IR_LOAD     = 1'b1;
          PC_INC      = 1'b1;
        end
        if (TIME_SIGNAL[2]) AR_LOAD = 1'b1;
      end else begin
        if (TIME_SIGNAL[0]) begin
          AR_CLEAR = 1'b1;
          TR_LOAD  = 1'b1;
        end
        if (TIME_SIGNAL[1]) begin
          MEMORY_WRITE = 1'b1;
          PC_CLEAR     = 1'b1;
        end
        if (TIME_SIGNAL[2]) begin
          PC_INC    = 1'b1;
          IEN_CLEAR = 1'b1;
        end
      end
      if (TIME_SIGNAL[3]) begin
        if (d_reg != OP_IO) begin
          if (i_reg) begin
            MEMORY_READ = 1'b1;
            AR_LOAD     = 1'b1;
          end
        end else if (!i_reg) begin
          ALU_CLEAR = IR[CLA_BIT];
          ALU_INC   = IR[INC_BIT];
          ALU_LOAD  = IR[CMA_BIT] | IR[CIR_BIT] | IR[CIL_BIT];
        end
      end
      case (d_reg)
        OP_AND, OP_ADD, OP_LDA: begin
          if (TIME_SIGNAL[4]) begin
            MEMORY_READ = 1'b1;
            DR_LOAD     = 1'b1;
          end
          if (TIME_SIGNAL[5]) ALU_LOAD = 1'b1;
        end
        OP_STA: begin
          if (TIME_SIGNAL[4]) MEMORY_WRITE = 1'b1;
        end
        OP_BUN: begin
          if (TIME_SIGNAL[4]) PC_LOAD = 1'b1;
        end
        OP_BSA: begin
          if (TIME_SIGNAL[4]) begin
            MEMORY_WRITE = 1'b1;
            AR_INC       = 1'b1;
          end
          if (TIME_SIGNAL[5]) PC_LOAD = 1'b1;
        end
        OP_ISZ: begin
          if (TIME_SIGNAL[4]) begin
            MEMORY_READ = 1'b1;
            DR_LOAD     = 1'b1;
          end
          if (TIME_SIGNAL[5]) DR_INC = 1'b1;
          // The datapath qualifies this PC_INC with its DR==0 detect.
          if (TIME_SIGNAL[6]) begin
            MEMORY_WRITE = 1'b1;
            PC_INC       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Parametrised successor of the hardwired basic-computer control unit. It owns the sequence counter, the decoded-opcode and indirect latches, the interrupt flip-flop R and a halt flag, so timing and decode no longer come from outside. It emits one-cycle register/memory strobes to the datapath and sits between the datapath IR and every register control input.

## Interface
- `WORD_W`, default 16: instruction width. IR[WORD_W-1] is I; IR[WORD_W-2 -: 3] is the opcode.
- `SC_W`, default 4: sequence counter width. TIME_SIGNAL has 2**SC_W bits; minimum legal value is 3.
- `CLK`  in  1: single clock, rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `ENABLE`  in  1: run enable. When low, all state holds and all strobes are 0.
- `IR`  in  WORD_W: datapath instruction register contents.
- `INTERRUPT_REQ`  in  1: IEN & (FGI | FGO), computed by the datapath.
- `TIME_SIGNAL`  out  2**SC_W: one-hot decode of the SC, Tn = bit n.
- `DEC_SIGNAL`  out  8: one-hot latched opcode, D0..D7.
- `INDIRECT_BIT`  out  1: latched I.
- `INTERRUPT_R`  out  1: R flip-flop.
- `HALTED`  out  1: halt flag.
- `SEQ_ERR`  out  1: one-cycle pulse on SC wrap.
- Strobes, all `out 1`: MEMORY_READ, MEMORY_WRITE, IR_LOAD, TR_LOAD, ALU_LOAD, ALU_CLEAR, ALU_INC, AR_LOAD, AR_INC, AR_CLEAR, DR_LOAD, DR_INC, PC_LOAD, PC_CLEAR, PC_INC, IEN_CLEAR.

## Operation
- Registered state: SC, D (3-bit opcode), I, R, HALT. Every strobe is combinational from state, gated by ENABLE & ~HALT.
- Reset values: SC=0, D=0, I=0, R=0, HALT=0, SEQ_ERR=0.
  - After reset: TIME_SIGNAL=1, DEC_SIGNAL=8'h01, INDIRECT_BIT=0, INTERRUPT_R=0, HALTED=0.
  - AR_LOAD=ENABLE. All other strobes 0.
- Fetch (R=0):
  - T0: AR_LOAD.
  - T1: MEMORY_READ, IR_LOAD, PC_INC.
  - T2: AR_LOAD. D latches IR opcode and I latches IR[WORD_W-1] at the end of T2.
- T3 when D≠7: MEMORY_READ and AR_LOAD if I=1, otherwise no strobe. Execute starts at T4.
- T3 when D=7 and I=0 (register reference):
  - ALU_CLEAR if IR[11].
  - ALU_INC if IR[5].
  - ALU_LOAD if any of IR[9], IR[7], IR[6].
  - HALT set if IR[0].
  - SC clears.
- T3 when D=7 and I=1 (I/O): no strobes, SC clears.
- Memory reference execute (SC clears at the listed last step):
  - D0, D1, D2: T4 MEMORY_READ and DR_LOAD; T5 ALU_LOAD (clear).
  - D3: T4 MEMORY_WRITE (clear).
  - D4: T4 PC_LOAD (clear).
  - D5: T4 MEMORY_WRITE and AR_INC; T5 PC_LOAD (clear).
  - D6: T4 MEMORY_READ and DR_LOAD; T5 DR_INC; T6 MEMORY_WRITE, plus PC_INC if the DR_ZERO convention holds in the datapath (clear).
- Interrupt cycle (R=1):
  - T0: AR_CLEAR, TR_LOAD.
  - T1: MEMORY_WRITE, PC_CLEAR.
  - T2: PC_INC, IEN_CLEAR. R clears and SC clears.
- R sets at the end of any enabled cycle where INTERRUPT_REQ=1, R=0, and T0, T1, T2 are all 0.
- HALT persists until RESET and freezes SC at 0.
- SC overflow (SC at max with no clear) wraps to 0 and pulses SEQ_ERR.

## Timing
- Strobe latency is zero: a strobe is asserted during its Tn cycle and acts at that cycle's closing edge.
- SC advances by 1 per enabled cycle. An SC clear takes priority over the increment, so the next cycle is T0.
- RESET mid-instruction: the next cycle is T0 with R=0 and HALT=0. No strobe from the aborted instruction reappears.
- ENABLE low: SC, D, I, R, HALT hold. R does not set. On re-enable, execution resumes at the held Tn.
- INTERRUPT_REQ during T3 of the final step of an instruction: R sets, so the next T0 is an interrupt cycle.
- HALT and interrupt in the same cycle: HALT wins and R does not set.

## Structure
- Package `cu_pkg`:
  - Opcode constants OP_AND..OP_IO (0..7).
  - Register-reference bit indices: CLA=11, INC=5, HLT=0.
  - Last-step constants per opcode.
- Sub-module `seq_counter`: SC_W-bit counter with sync clear, increment enable and a one-hot decode output of width 2**SC_W.

## Test plan
- RESET, then IR=16'h2005 (LDA, direct) → strobes on T0..T5 exactly as listed, DEC_SIGNAL=8'h04, SC returns to T0 after T5.
- IR=16'hA005 (indirect LDA) → MEMORY_READ and AR_LOAD at T3, INDIRECT_BIT=1 from T3 onward.
- IR=16'h7800 (CLA) → ALU_CLEAR at T3, next cycle T0. Then IR=16'h7001 → HALTED=1 and TIME_SIGNAL stays 1 with no strobes for 20 cycles.
- INTERRUPT_REQ=1 asserted at T4 of an STA → R=1, then AR_CLEAR+TR_LOAD at T0, MEMORY_WRITE+PC_CLEAR at T1, PC_INC+IEN_CLEAR at T2, R=0 afterwards.
- RESET pulsed during T5 of ISZ → next cycle T0, DR_INC and MEMORY_WRITE never asserted. ENABLE low for 3 cycles at T4 → T4 resumes unchanged.
